// File: rtl/seg_p2s_pkg.sv
// Shared constants and state encoding for the segment serial transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seg_p2s_pkg;

    localparam int SEG_PER_DIGIT = 8;                     // {p,g,f,e,d,c,b,a}
    localparam int DIGITS        = 8;
    localparam int SEG_W         = DIGITS * SEG_PER_DIGIT; // 64-bit image

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

endpackage

// File: rtl/seg_p2s_tick.sv
// Half-period timer: counts CLK_DIV system clocks, tc marks the last one.
// Latency: tc is combinational from the count register; the count wraps on tc.
// Backpressure: none; clr holds the count at zero.
//
// Ports: clk, rst_n (async active-low), clr (hold at zero), tc (terminal count).
// CLK_DIV must be >= 1; with CLK_DIV=1 tc is high every cycle.
module seg_p2s_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tc
);

    localparam int             W    = $clog2(CLK_DIV) + 1;
    localparam logic [W-1:0]   LAST = W'(CLK_DIV - 1);

    logic [W-1:0] div_cnt;

    assign tc = (div_cnt == LAST);

    // Wrapping on tc means every state starts its phase with a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (clr || tc) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_p2s_tx.sv
// Snapshots a 64-bit segment image, shifts it into a 74HC595-style chain, pulses the latch.
// Latency: frame occupies 129*CLK_DIV cycles from the start edge; done pulses as busy falls.
// Backpressure: start is ignored (not queued) while busy; accepted again in the done cycle.
//
// Ports: clk, rst_n (async active-low), seg_txt[63:0] (image, digit 7 in [63:56]),
//        start (frame request), seg_clk/seg_sout/seg_lat/seg_clrn (chain pins),
//        busy (frame in progress), done (one-cycle end-of-frame pulse).
// Build option: define SEG_P2S_AUTO_EN to start a frame automatically after
//               REFRESH_CYC consecutive idle cycles.
module seg_p2s_tx
    import seg_p2s_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int MSB_FIRST   = 1,
    parameter int REFRESH_CYC = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEG_W-1:0] seg_txt,
    input  logic             start,
    output logic             seg_clk,
    output logic             seg_sout,
    output logic             seg_lat,
    output logic             seg_clrn,
    output logic             busy,
    output logic             done
);

    localparam bit MSB = (MSB_FIRST != 0);

    state_t           state, state_nxt;
    logic             tick_tc;
    logic             go;
    logic [SEG_W-1:0] shreg;
    logic [5:0]       bit_cnt;
    logic             last_bit;
    logic             clk_nxt, lat_nxt, busy_nxt, done_nxt;

    assign last_bit = (bit_cnt == 6'd63);

    seg_p2s_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == IDLE),
        .tc    (tick_tc)
    );

`ifdef SEG_P2S_AUTO_EN
    localparam int            RW       = $clog2(REFRESH_CYC + 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYC - 1);

    logic [RW-1:0] ref_cnt;

    // Counts consecutive idle cycles; the REFRESH_CYC-th one launches a frame.
    assign go = start || ((state == IDLE) && (ref_cnt == REF_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt <= '0;
        end else if ((state != IDLE) || go) begin
            ref_cnt <= '0;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end
`else
    // REFRESH_CYC only has meaning with auto refresh; keep it referenced here.
    localparam int unused_refresh_cyc = REFRESH_CYC;

    assign go = start;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (go)      state_nxt = SHIFT_LO;
            SHIFT_LO: if (tick_tc) state_nxt = SHIFT_HI;
            SHIFT_HI: if (tick_tc) state_nxt = last_bit ? LATCH : SHIFT_LO;
            LATCH:    if (tick_tc) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Output logic: pins are decoded from the next state so they register
    // together with the state itself.
    always_comb begin
        clk_nxt  = (state_nxt == SHIFT_HI);
        lat_nxt  = (state_nxt == LATCH);
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state == LATCH) && (state_nxt == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_clk  <= 1'b0;
            seg_lat  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            seg_clrn <= 1'b0;
        end else begin
            seg_clk  <= clk_nxt;
            seg_lat  <= lat_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            seg_clrn <= 1'b1;
        end
    end

    // Shift register. The outgoing bit sits at the head of shreg, so seg_sout
    // moves only on the load edge and on the HI->LO edge that shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if ((state == IDLE) && go) begin
            shreg   <= seg_txt;
            bit_cnt <= '0;
        end else if ((state == SHIFT_HI) && tick_tc && !last_bit) begin
            shreg   <= MSB ? {shreg[SEG_W-2:0], 1'b0} : {1'b0, shreg[SEG_W-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign seg_sout = MSB ? shreg[SEG_W-1] : shreg[0];

endmodule

// File: tb/tb_seg_p2s_tx.sv
// Bench for seg_p2s_tx: two instances (MSB-first and LSB-first) share all inputs;
// a negedge monitor records the chain-visible waveform and a spec-level model
// predicts the bit stream, frame length, latch width and done pulses.
module tb_seg_p2s_tx;

    typedef struct {
        logic [63:0] txt;
        int          busy_len;
        int          lat_len;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] seg_txt = '0;
    logic [1:0]  m_clk, m_sout, m_lat, m_clrn, m_busy, m_done;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    seg_p2s_tx #(.CLK_DIV(2), .MSB_FIRST(1), .REFRESH_CYC(10)) dut_msb (
        .clk(clk), .rst_n(rst_n), .seg_txt(seg_txt), .start(start),
        .seg_clk(m_clk[0]), .seg_sout(m_sout[0]), .seg_lat(m_lat[0]),
        .seg_clrn(m_clrn[0]), .busy(m_busy[0]), .done(m_done[0])
    );

    seg_p2s_tx #(.CLK_DIV(2), .MSB_FIRST(0), .REFRESH_CYC(10)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .seg_txt(seg_txt), .start(start),
        .seg_clk(m_clk[1]), .seg_sout(m_sout[1]), .seg_lat(m_lat[1]),
        .seg_clrn(m_clrn[1]), .busy(m_busy[1]), .done(m_done[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    bit         cap_q [2][$];
    int         rise_q[$];
    int         busy_run[2], last_busy[2], lat_run[2], last_lat[2];
    int         lat_pulses[2], done_cnt[2], rise_cnt[2], viol[2];
    int         done_ref[2], latp_ref[2];
    logic [1:0] p_clk = '0, p_sout = '0, p_busy = '0;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_busy[i] && !p_busy[i]) begin
                cap_q[i].delete();
                rise_cnt[i]++;
                if (i == 0) rise_q.push_back(cyc);
            end
            if (m_clk[i] && !p_clk[i]) cap_q[i].push_back(m_sout[i]);
            // Data may move only on a falling serial clock or at frame start.
            if (rst_n && (m_sout[i] !== p_sout[i]) && !(p_clk[i] && !m_clk[i])
                && !(m_busy[i] && !p_busy[i])) viol[i]++;
            if (m_busy[i]) busy_run[i]++;
            else if (busy_run[i] != 0) begin last_busy[i] = busy_run[i]; busy_run[i] = 0; end
            if (m_lat[i]) lat_run[i]++;
            else if (lat_run[i] != 0) begin
                last_lat[i] = lat_run[i]; lat_run[i] = 0; lat_pulses[i]++;
            end
            if (m_done[i]) done_cnt[i]++;
        end
        p_clk  = m_clk;
        p_sout = m_sout;
        p_busy = m_busy;
    end

    // ---------------- reference model ----------------
    // k-th bit placed on the wire for a given image and shift order.
    function automatic bit stream_bit(input logic [63:0] v, input bit msb, input int k);
        return msb ? v[63-k] : v[k];
    endfunction

    function automatic logic [5:0] outs(input int i);
        return {m_clk[i], m_sout[i], m_lat[i], m_busy[i], m_done[i], m_clrn[i]};
    endfunction

    task automatic start_frame(input logic [63:0] v);
        done_ref = done_cnt;
        latp_ref = lat_pulses;
        @(posedge clk); #1 seg_txt = v; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (m_done[0]) begin seen = 1'b1; break; end
        end
        #2;
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic check_frame(input string tag, input logic [63:0] snap,
                               input int blen, input int llen);
        for (int i = 0; i < 2; i++) begin
            logic [63:0] act, exp;
            act = '0;
            exp = '0;
            for (int k = 0; k < 64; k++) begin
                exp[k] = stream_bit(snap, (i == 0), k);
                if (k < cap_q[i].size()) act[k] = cap_q[i][k];
            end
            chk($sformatf("%s_stream%0d", tag, i), act, exp);
            chk($sformatf("%s_nbits%0d", tag, i), 64'(cap_q[i].size()), 64'd64);
            chk($sformatf("%s_busy_len%0d", tag, i), 64'(last_busy[i]), 64'(blen));
            chk($sformatf("%s_lat_len%0d", tag, i), 64'(last_lat[i]), 64'(llen));
            chk($sformatf("%s_done_cnt%0d", tag, i), 64'(done_cnt[i] - done_ref[i]), 64'd1);
            chk($sformatf("%s_lat_cnt%0d", tag, i), 64'(lat_pulses[i] - latp_ref[i]), 64'd1);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t        vecs[6];
        int          rel_cyc;
        int          ld[2], lp[2];
        logic [63:0] a;

        vecs[0] = '{64'h8000_0000_0000_0001, 258, 2};
        vecs[1] = '{64'hC0F9_A4B0_9992_82F8, 258, 2};
        for (int i = 2; i < 6; i++) vecs[i] = '{{$urandom, $urandom}, 258, 2};

        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("reset_outs0", 64'(outs(0)), 64'd0);
            chk("reset_outs1", 64'(outs(1)), 64'd0);
        end
        #1 rst_n = 1'b1;
        #1 chk("clrn_before_edge", 64'(m_clrn), 64'd0);
        rel_cyc = cyc;
        @(negedge clk);
        chk("post_release0", 64'(outs(0)), 64'b000001);
        chk("post_release1", 64'(outs(1)), 64'b000001);

`ifdef SEG_P2S_AUTO_EN
        for (int c = 0; c < 1000 && rise_q.size() < 3; c++) @(negedge clk);
        chk("auto_three_frames", 64'(rise_q.size() >= 3), 64'd1);
        if (rise_q.size() >= 3) begin
            chk("auto_first_start", 64'(rise_q[0] - rel_cyc), 64'd10);
            chk("auto_period1", 64'(rise_q[1] - rise_q[0]), 64'd268);
            chk("auto_period2", 64'(rise_q[2] - rise_q[1]), 64'd268);
        end
        chk("auto_done_cnt", 64'(done_cnt[0]), 64'd2);
`else
        repeat (30) @(negedge clk);
        chk("no_autostart", 64'(rise_cnt[0]), 64'd0);

        // Table frames: directed images plus random ones, random idle gaps.
        for (int i = 0; i < 6; i++) begin
            start_frame(vecs[i].txt);
            wait_done($sformatf("vec%0d", i));
            check_frame($sformatf("vec%0d", i), vecs[i].txt, vecs[i].busy_len, vecs[i].lat_len);
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end

        // Image change and start pulses mid-frame are ignored.
        a = 64'h0123_4567_89AB_CDEF;
        start_frame(a);
        for (int c = 1; c <= 110; c++) begin
            @(posedge clk); #1;
            if (c == 50)  seg_txt = '1;
            if (c == 60)  start = 1'b1;
            if (c == 61)  start = 1'b0;
            if (c == 100) start = 1'b1;
            if (c == 101) start = 1'b0;
        end
        wait_done("snap");
        check_frame("snap", a, 258, 2);

        // start during the done cycle launches a frame on the very next edge.
        done_ref = done_cnt;
        latp_ref = lat_pulses;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("done_cycle_start", 64'(m_busy), 64'd3);
        wait_done("restart");
        check_frame("restart", 64'hFFFF_FFFF_FFFF_FFFF, 258, 2);

        // Random start and image noise while busy.
        for (int r = 0; r < 2; r++) begin
            a = {$urandom, $urandom};
            start_frame(a);
            for (int c = 1; c <= 200; c++) begin
                @(posedge clk); #1;
                start   = 1'($urandom_range(0, 1));
                seg_txt = {$urandom, $urandom};
            end
            start = 1'b0;
            wait_done($sformatf("noise%0d", r));
            check_frame($sformatf("noise%0d", r), a, 258, 2);
        end

        // Reset mid-frame: outputs clear at once, nothing is latched.
        ld = done_cnt;
        lp = lat_pulses;
        start_frame({$urandom, $urandom});
        repeat (119) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset0", 64'(outs(0)), 64'd0);
        chk("async_reset1", 64'(outs(1)), 64'd0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (300) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_no_done%0d", i), 64'(done_cnt[i] - ld[i]), 64'd0);
            chk($sformatf("rst_no_lat%0d", i), 64'(lat_pulses[i] - lp[i]), 64'd0);
        end
        chk("rst_idle_busy", 64'(m_busy), 64'd0);

        // Normal operation resumes after the abort.
        a = {$urandom, $urandom};
        start_frame(a);
        wait_done("recover");
        check_frame("recover", a, 258, 2);

        chk("sout_stable0", 64'(viol[0]), 64'd0);
        chk("sout_stable1", 64'(viol[1]), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_p2s_tx.md
Name: seg_p2s_tx

Overview:
- Serial transmitter for the 64-bit segment image (8 digits × {p,g,f,e,d,c,b,a}) produced by the hex-to-segment encoder.
- Snapshots the image, shifts it bit-serially into the board's external 74HC595-style segment shift chain, then pulses a latch.
- Sits between the segment encoder and the display pins; one instance per display.

Parameters:
- CLK_DIV, 2, system clocks per serial-clock half period (≥1).
- MSB_FIRST, 1, 1: seg_txt[63] shifted first; 0: seg_txt[0] first.
- REFRESH_CYC, 100000, idle cycles between automatic frames (used only with SEG_P2S_AUTO_EN).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg_txt  in  64  segment image; bits [63:56] digit 7 … [7:0] digit 0.
- start  in  1  frame request, sampled only in IDLE.
- seg_clk  out  1  serial shift clock to chain.
- seg_sout  out  1  serial data, stable across every seg_clk rising edge.
- seg_lat  out  1  storage latch strobe to chain.
- seg_clrn  out  1  chain clear, active low.
- busy  out  1  frame in progress.
- done  out  1  one-cycle end-of-frame pulse.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: seg_clk=0, seg_sout=0, seg_lat=0, busy=0, done=0. seg_clrn=0 while rst_n=0 and 1 from the first clk edge after release. State=IDLE; counters=0.
- All outputs are registered.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE:
  - seg_clk=0, seg_lat=0.
  - On a clk edge with start=1, load shift register ← seg_txt and drive seg_sout ← first bit (per MSB_FIRST).
  - Same edge: bit_cnt←0, div_cnt←0, busy←1, → SHIFT_LO.
- SHIFT_LO: seg_clk=0 for CLK_DIV cycles, then → SHIFT_HI.
- SHIFT_HI:
  - seg_clk=1 for CLK_DIV cycles. The chain samples on the 0→1 edge.
  - At the end of HI, if bit_cnt=63 → LATCH.
  - Otherwise shift, present the next bit on seg_sout, bit_cnt+1, → SHIFT_LO.
  - seg_sout changes only together with the 1→0 transition of seg_clk.
- LATCH: seg_clk=0, seg_lat=1 for CLK_DIV cycles, then → IDLE with busy←0, seg_lat←0, done←1 for exactly one cycle.
- Frame length: busy high for 129·CLK_DIV cycles (CLK_DIV=2 → 258). done is asserted on the edge busy falls.
- div_cnt width: $clog2(CLK_DIV)+1. bit_cnt is 6 bits and saturates the frame at 63, never wraps.
- seg_txt changes during a frame are ignored; the snapshot is used.
- start while busy is ignored and not queued. start in the done cycle (state already IDLE) is accepted.
- rst_n low mid-frame: immediate return to IDLE, seg_lat never pulses, partial data is not latched.

Optional Feature:
- SEG_P2S_AUTO_EN defined:
  - A refresh counter runs in IDLE. After REFRESH_CYC consecutive IDLE cycles, a frame starts exactly as if start=1.
  - The counter clears on any frame start. start still forces an immediate frame.
- SEG_P2S_AUTO_EN undefined: frames start only on start; no refresh counter is synthesized.

Decomposition:
- Package seg_p2s_pkg holds:
  - constant SEG_W=64, DIGITS=8;
  - state enum {IDLE, SHIFT_LO, SHIFT_HI, LATCH}.
- One sub-module, seg_p2s_tick: CLK_DIV half-period counter with clear input and terminal-count output. It is reused by SHIFT_LO/HI/LATCH.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles → all outputs 0, seg_clrn=0; release → seg_clrn=1 next edge, others stay 0.
- CLK_DIV=2, MSB_FIRST=1, seg_txt=64'h8000_0000_0000_0001, start pulse → bits captured on seg_clk rises = 1, 62×0, 1; busy=1 for 258 cycles; seg_lat=1 for 2 cycles; single done pulse.
- MSB_FIRST=0, seg_txt=64'hC0F9_A4B0_9992_82F8 → captured stream equals seg_txt[0]..seg_txt[63].
- Change seg_txt to 64'hFFFF_FFFF_FFFF_FFFF at cycle 50 of a frame, plus start pulses at cycles 60 and 100 → stream equals original snapshot, only one frame, one done. start in the done cycle → second frame begins next edge.
- rst_n low at cycle 120 of a frame → outputs return to reset values asynchronously, no seg_lat pulse, no done.
- With SEG_P2S_AUTO_EN, REFRESH_CYC=10, start tied 0 → first frame begins after 10 IDLE cycles post-reset and repeats every 10 + 258 cycles.
